// File: rtl/irq_req_latch_if.sv
// irq_req_latch_if: request/service signal bundle between the request latch and its environment
interface irq_req_latch_if;
   logic [15:0] req_in;
   logic [15:0] mask;
   logic [15:0] pend_out;
   logic        pend_any;
   logic [3:0]  svc_idx;
   logic        svc_ack;
   logic        svc_err;
   logic [15:0] ovf;
   logic        ovf_clr;
   modport master (
      output req_in, mask, svc_idx, svc_ack, ovf_clr,
      input  pend_out, pend_any, svc_err, ovf
   );
   modport slave (
      input  req_in, mask, svc_idx, svc_ack, ovf_clr,
      output pend_out, pend_any, svc_err, ovf
   );
endinterface

// File: rtl/irq_req_latch.sv
// irq_req_latch: synchronises 16 request lines, latches events until acked, presents masked pending vector
module irq_req_latch #(
   parameter int SYNC_STAGES = 2,
   parameter bit EDGE_MODE   = 1'b1
) (
   input logic             clk,
   input logic             rst,
   irq_req_latch_if.slave  bus
);
   logic [SYNC_STAGES-1:0][15:0] r_sync;
   logic [15:0] r_s_d;
   logic [15:0] r_pend;
   logic [15:0] r_ovf;
   logic        r_err;
   logic [15:0] w_s;
   logic [15:0] w_ev;
   logic [15:0] w_clr;
   logic [15:0] w_pend_nxt;
   logic [15:0] w_ovf_nxt;
   always_comb begin
      w_s        = r_sync[SYNC_STAGES-1];
      w_ev       = EDGE_MODE ? (w_s & ~r_s_d) : w_s;
      w_clr      = bus.svc_ack ? (16'h1 << bus.svc_idx) : 16'h0;
      // a fresh event on the acked bit wins over the clear
      w_pend_nxt = w_ev | (r_pend & ~w_clr);
      w_ovf_nxt  = (r_ovf & ~{16{bus.ovf_clr}}) | (EDGE_MODE ? (w_ev & r_pend & ~w_clr) : 16'h0);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
         r_s_d  <= '0;
         r_pend <= '0;
         r_ovf  <= '0;
         r_err  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.req_in};
         r_s_d  <= w_s;
         r_pend <= w_pend_nxt;
         r_ovf  <= w_ovf_nxt;
         r_err  <= bus.svc_ack & ~r_pend[bus.svc_idx];
      end
   end
   assign bus.pend_out = r_pend & bus.mask;
   assign bus.pend_any = |bus.pend_out;
   assign bus.svc_err  = r_err;
   assign bus.ovf      = r_ovf;
endmodule

// File: tb/tb_irq_req_latch.sv
// tb_irq_req_latch: directed scenarios plus randomized run against a cycle-level reference model
module tb_irq_req_latch;
   localparam int SYNC = 2;
   localparam bit EDGE = 1'b1;
   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [15:0] hist [SYNC+1];
   logic [15:0] m_pend, m_ovf;
   logic        m_err;
   irq_req_latch_if bus ();
   irq_req_latch #(.SYNC_STAGES(SYNC), .EDGE_MODE(EDGE)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // model: s is req_in as sampled SYNC edges earlier; reset edges sample as 0
   task automatic step();
      logic [15:0] s, sd, ev;
      logic clr;
      s  = hist[SYNC-1];
      sd = hist[SYNC];
      ev = EDGE ? (s & ~sd) : s;
      @(posedge clk);
      if (rst) begin
         m_pend = '0;
         m_ovf  = '0;
         m_err  = 1'b0;
         for (int k = 0; k <= SYNC; k++) hist[k] = '0;
      end else begin
         m_err = bus.svc_ack && !m_pend[bus.svc_idx];
         if (bus.ovf_clr) m_ovf = '0;
         for (int i = 0; i < 16; i++) begin
            clr = bus.svc_ack && (bus.svc_idx == i);
            if (EDGE && ev[i] && m_pend[i] && !clr) m_ovf[i] = 1'b1;
            if (ev[i]) m_pend[i] = 1'b1;
            else if (clr) m_pend[i] = 1'b0;
         end
         for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = bus.req_in;
      end
      #1;
   endtask
   task automatic steps(input int n);
      for (int j = 0; j < n; j++) step();
   endtask
   task automatic test_reset();
      rst = 1'b1;
      bus.req_in = '0; bus.mask = 16'hFFFF; bus.svc_idx = '0; bus.svc_ack = 1'b0; bus.ovf_clr = 1'b0;
      steps(3);
      rst = 1'b0;
      n_tests++; if (bus.pend_out !== 16'h0) begin n_fail++; $display("FAIL reset_pend_out got %h want 0000", bus.pend_out); end
      n_tests++; if (bus.pend_any !== 1'b0) begin n_fail++; $display("FAIL reset_pend_any got %b want 0", bus.pend_any); end
      n_tests++; if (bus.ovf !== 16'h0) begin n_fail++; $display("FAIL reset_ovf got %h want 0000", bus.ovf); end
      n_tests++; if (bus.svc_err !== 1'b0) begin n_fail++; $display("FAIL reset_svc_err got %b want 0", bus.svc_err); end
   endtask
   task automatic test_single_edge();
      bus.req_in[5] = 1'b1;
      steps(2);
      n_tests++; if (bus.pend_out !== 16'h0) begin n_fail++; $display("FAIL edge_early got %h want 0000", bus.pend_out); end
      step();
      n_tests++; if (bus.pend_out !== 16'h0020) begin n_fail++; $display("FAIL edge_latency got %h want 0020", bus.pend_out); end
      n_tests++; if (bus.pend_any !== 1'b1) begin n_fail++; $display("FAIL edge_any got %b want 1", bus.pend_any); end
      steps(3);
      n_tests++; if (bus.pend_out !== 16'h0020) begin n_fail++; $display("FAIL edge_hold got %h want 0020", bus.pend_out); end
   endtask
   task automatic test_ack_collision();
      bus.svc_ack = 1'b1; bus.svc_idx = 4'd5;
      step();
      bus.svc_ack = 1'b0;
      n_tests++; if (bus.pend_out !== 16'h0) begin n_fail++; $display("FAIL ack_clear got %h want 0000", bus.pend_out); end
      bus.req_in[5] = 1'b0; steps(3);
      bus.req_in[5] = 1'b1; steps(3);
      bus.req_in[5] = 1'b0; steps(3);
      bus.req_in[5] = 1'b1; steps(2);
      bus.svc_ack = 1'b1; bus.svc_idx = 4'd5;
      step();
      bus.svc_ack = 1'b0;
      n_tests++; if (bus.pend_out !== 16'h0020) begin n_fail++; $display("FAIL set_wins got %h want 0020", bus.pend_out); end
      n_tests++; if (bus.ovf !== 16'h0) begin n_fail++; $display("FAIL set_wins_ovf got %h want 0000", bus.ovf); end
      bus.req_in[5] = 1'b0; bus.svc_ack = 1'b1;
      step();
      bus.svc_ack = 1'b0;
      steps(3);
   endtask
   task automatic test_mask_hold();
      bus.mask = 16'h7FFF; bus.req_in[15] = 1'b1;
      steps(4);
      n_tests++; if (bus.pend_out !== 16'h0) begin n_fail++; $display("FAIL mask_hidden got %h want 0000", bus.pend_out); end
      n_tests++; if (bus.pend_any !== 1'b0) begin n_fail++; $display("FAIL mask_any got %b want 0", bus.pend_any); end
      bus.mask = 16'hFFFF;
      #1;
      n_tests++; if (bus.pend_out !== 16'h8000) begin n_fail++; $display("FAIL mask_reveal got %h want 8000", bus.pend_out); end
      bus.svc_ack = 1'b1; bus.svc_idx = 4'd15; bus.req_in[15] = 1'b0;
      step();
      bus.svc_ack = 1'b0;
      steps(3);
   endtask
   task automatic test_overflow();
      bus.req_in[3] = 1'b1; steps(3);
      bus.req_in[3] = 1'b0; steps(3);
      bus.req_in[3] = 1'b1; steps(3);
      n_tests++; if (bus.ovf !== 16'h0008) begin n_fail++; $display("FAIL ovf_set got %h want 0008", bus.ovf); end
      bus.ovf_clr = 1'b1; step(); bus.ovf_clr = 1'b0;
      n_tests++; if (bus.ovf !== 16'h0) begin n_fail++; $display("FAIL ovf_clr got %h want 0000", bus.ovf); end
      bus.req_in[3] = 1'b0; steps(3);
      bus.req_in[3] = 1'b1; steps(2);
      bus.ovf_clr = 1'b1; step(); bus.ovf_clr = 1'b0;
      n_tests++; if (bus.ovf !== 16'h0008) begin n_fail++; $display("FAIL ovf_clr_collide got %h want 0008", bus.ovf); end
      bus.req_in[3] = 1'b0; bus.svc_ack = 1'b1; bus.svc_idx = 4'd3; bus.ovf_clr = 1'b1;
      step();
      bus.svc_ack = 1'b0; bus.ovf_clr = 1'b0;
      steps(3);
   endtask
   task automatic test_spurious_ack();
      n_tests++; if (bus.pend_out !== 16'h0) begin n_fail++; $display("FAIL spur_pre got %h want 0000", bus.pend_out); end
      bus.svc_ack = 1'b1; bus.svc_idx = 4'd9;
      step();
      bus.svc_ack = 1'b0;
      n_tests++; if (bus.svc_err !== 1'b1) begin n_fail++; $display("FAIL spur_err got %b want 1", bus.svc_err); end
      n_tests++; if (bus.pend_out !== 16'h0) begin n_fail++; $display("FAIL spur_pend got %h want 0000", bus.pend_out); end
      step();
      n_tests++; if (bus.svc_err !== 1'b0) begin n_fail++; $display("FAIL spur_err_pulse got %b want 0", bus.svc_err); end
   endtask
   task automatic test_simul_reset();
      bus.req_in = 16'h1081; steps(3);
      n_tests++; if (bus.pend_out !== 16'h1081) begin n_fail++; $display("FAIL simul got %h want 1081", bus.pend_out); end
      bus.req_in = 16'h0080; rst = 1'b1;
      steps(2);
      rst = 1'b0;
      n_tests++; if ({bus.pend_out, bus.ovf, bus.pend_any, bus.svc_err} !== 34'h0) begin n_fail++; $display("FAIL midreset got pend %h ovf %h any %b err %b want all 0", bus.pend_out, bus.ovf, bus.pend_any, bus.svc_err); end
      steps(3);
      n_tests++; if (bus.pend_out !== 16'h0080) begin n_fail++; $display("FAIL refire got %h want 0080", bus.pend_out); end
      steps(4);
      n_tests++; if (bus.ovf !== 16'h0) begin n_fail++; $display("FAIL refire_once got ovf %h want 0000", bus.ovf); end
   endtask
   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         bus.req_in  = bus.req_in ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
         bus.mask    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : bus.mask;
         bus.svc_ack = ($urandom_range(0, 2) == 0);
         bus.svc_idx = 4'($urandom);
         bus.ovf_clr = ($urandom_range(0, 9) == 0);
         rst         = ($urandom_range(0, 149) == 0);
         step();
         n_tests++; if (bus.pend_out !== (m_pend & bus.mask)) begin n_fail++; $display("FAIL rnd_pend_out cyc %0d got %h want %h", c, bus.pend_out, m_pend & bus.mask); end
         n_tests++; if (bus.pend_any !== |(m_pend & bus.mask)) begin n_fail++; $display("FAIL rnd_pend_any cyc %0d got %b want %b", c, bus.pend_any, |(m_pend & bus.mask)); end
         n_tests++; if (bus.ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc %0d got %h want %h", c, bus.ovf, m_ovf); end
         n_tests++; if (bus.svc_err !== m_err) begin n_fail++; $display("FAIL rnd_svc_err cyc %0d got %b want %b", c, bus.svc_err, m_err); end
      end
      rst = 1'b0; bus.svc_ack = 1'b0; bus.ovf_clr = 1'b0;
   endtask
   initial begin
      for (int k = 0; k <= SYNC; k++) hist[k] = '0;
      m_pend = '0; m_ovf = '0; m_err = 1'b0;
      #2;
      test_reset();
      test_single_edge();
      test_ack_collision();
      test_mask_hold();
      test_overflow();
      test_spurious_ack();
      test_simul_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
